game_time_display: RTL

- Display stage fed by the tenths-of-second game counter (10-bit count of 0.1 s ticks) and driving the board's 4-digit multiplexed 7-segment display.
- Watches the counter and, on each change, runs a sequential shift-add-3 (double-dabble) binary-to-BCD conversion.
- Scans the four BCD digits as "SSS.T" (max 102.3), with a decimal point after the seconds digit and leading-zero blanking.

---
 rtl/game_disp_pkg.sv | 17 +
 rtl/game_time_display_if.sv | 13 +
 rtl/game_time_display_seg7_decode.sv | 29 ++
 rtl/game_time_display.sv | 81 ++++++++
 4 files changed

// File: rtl/game_disp_pkg.sv
// game_disp_pkg: conversion FSM states and 7-segment codes ({dp,g,f,e,d,c,b,a}, active-high)
package game_disp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam int DP_BIT = 7;
endpackage

// File: rtl/game_time_display_if.sv
// game_time_display_if: time input from the game counter and display-side outputs
//   time_in: tenths of seconds; bcd_out/valid/busy: conversion result and status;
//   digit_sel/seg_out: scanned 7-segment drive. slave = display, master = source/observer.
interface game_time_display_if #(parameter int W = 10);
  logic [W-1:0] time_in;
  logic [15:0] bcd_out;
  logic valid;
  logic busy;
  logic [3:0] digit_sel;
  logic [7:0] seg_out;
  modport master(output time_in, input bcd_out, valid, busy, digit_sel, seg_out);
  modport slave(input time_in, output bcd_out, valid, busy, digit_sel, seg_out);
endinterface

// File: rtl/game_time_display_seg7_decode.sv
// seg7_decode: one BCD nibble to 7-segment code with decimal point and blanking
//   bcd: digit value (10..15 show a dash); blank: force all segments off; dp: light the decimal point
module seg7_decode
  import game_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [7:0] code;
  always_comb begin
    code = SEG_DASH;
    case (bcd)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = SEG_DASH;
    endcase
  end
  assign seg = blank ? SEG_BLANK : (code | (8'(dp) << DP_BIT));
endmodule

// File: rtl/game_time_display.sv
// game_time_display: double-dabble conversion of the tenths counter, scanned as "SSS.T"
//   CLOCK10M: clock; KEY0: async active-high reset; bus: time_in in, bcd_out/valid/busy/digit_sel/seg_out out
module game_time_display
  import game_disp_pkg::*;
#(
  parameter int W = 10,
  parameter int SCAN_DIV = 10000,
  parameter int BLANK_LEADING = 1
) (
  input logic CLOCK10M,
  input logic KEY0,
  game_time_display_if.slave bus
);
  localparam int IW = $clog2(W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  state_t state;
  logic [W-1:0] shreg, last;
  logic [15:0] scratch, adj;
  logic [IW-1:0] iter;
  logic [PW-1:0] pre;
  logic [1:0] idx;
  logic [3:0] dig;
  logic blank;
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign adj[4*n +: 4] = scratch[4*n +: 4] >= 4'd5 ? scratch[4*n +: 4] + 4'd3 : scratch[4*n +: 4];
  end
  always_ff @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      state <= IDLE;
      shreg <= '0;
      last <= '0;
      scratch <= '0;
      iter <= '0;
      bus.bcd_out <= '0;
      bus.valid <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.time_in != last || !bus.valid) begin
          shreg <= bus.time_in;
          last <= bus.time_in;
          scratch <= '0;
          iter <= IW'(W);
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          iter <= iter - 1'b1;
          if (iter == IW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          bus.bcd_out <= scratch;
          bus.valid <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      pre <= '0;
      idx <= '0;
      bus.digit_sel <= 4'b0001;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= idx + 1'b1;
      bus.digit_sel <= {bus.digit_sel[2:0], bus.digit_sel[3]};
    end else begin
      pre <= pre + 1'b1;
    end
  end
  assign dig = bus.bcd_out[4*idx +: 4];
  // digit2 only blanks when digit3 is also zero, so interior zeros stay visible
  assign blank = !bus.valid || (BLANK_LEADING != 0 &&
                 ((idx == 2'd3 && bus.bcd_out[15:12] == 4'd0) ||
                  (idx == 2'd2 && bus.bcd_out[15:8] == 8'd0)));
  seg7_decode u_dec (.bcd(dig), .blank(blank), .dp(idx == 2'd1), .seg(bus.seg_out));
endmodule
